// File: rtl/switch_pkg.sv
// switch_pkg: shared defaults and types for the output-bus arbiter.
package switch_pkg;
    localparam int NUM_PORTS_DFLT = 4;
    localparam int WEIGHT_W_DFLT  = 4;
    localparam int MAX_BEATS_DFLT = 16;
    typedef enum logic {IDLE, GRANT} arb_state_e;
    typedef logic [$clog2(NUM_PORTS_DFLT)-1:0] port_id_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set bit of elig_i scanning upward from ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int  N    = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    elig_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [ID_W-1:0] win_o,
    output logic            found_o
);
    logic [ID_W-1:0] idx;
    always_comb begin
        win_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        // Scan from the farthest offset down so the nearest eligible port wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr_i) + k) % N);
            if (elig_i[idx]) begin
                win_o   = idx;
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter that locks the bus for a whole packet,
// with a beat-limit watchdog that force-releases a stuck grant.
module wrr_burst_arbiter
    import switch_pkg::*;
#(
    parameter int  NUM_PORTS      = NUM_PORTS_DFLT,
    parameter int  WEIGHT_W       = WEIGHT_W_DFLT,
    parameter int  DEFAULT_WEIGHT = 1,
    parameter int  MAX_BEATS      = MAX_BEATS_DFLT,
    parameter int  BEAT_W         = 5,
    localparam int ID_W           = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          last_i,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight_i,
    input  logic                          cfg_load_i,
    output logic [NUM_PORTS-1:0]          grant_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_o
);
    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      gid_q, gid_d, ptr_q, ptr_d, win;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [WEIGHT_W-1:0]  weight_q [NUM_PORTS];
    logic [WEIGHT_W-1:0]  weight_d [NUM_PORTS];
    logic [WEIGHT_W-1:0]  credit_q [NUM_PORTS];
    logic [WEIGHT_W-1:0]  credit_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] has_w, elig_now, elig;
    logic                 refill, found, beat, last_beat, wd_hit, release_g;

    // A refill makes every weighted requester eligible this same cycle, so no bubble.
    always_comb begin
        has_w    = '0;
        elig_now = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            has_w[i]    = weight_q[i] != '0;
            elig_now[i] = req_i[i] && has_w[i] && credit_q[i] != '0;
        end
        refill    = state_q == IDLE && elig_now == '0 && (req_i & has_w) != '0;
        elig      = refill ? (req_i & has_w) : elig_now;
        beat      = req_i[gid_q];
        last_beat = beat && last_i[gid_q];
        wd_hit    = beat && !last_i[gid_q] && beat_q >= BEAT_W'(MAX_BEATS);
        release_g = state_q == GRANT && (!beat || last_beat || wd_hit);
    end

    rr_pick #(.N(NUM_PORTS)) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .found_o (found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (found ? GRANT : IDLE) : (release_g ? IDLE : GRANT);
    end

    always_comb begin
        grant_o    = grant_q;
        grant_id_o = gid_q;
        busy_o     = state_q == GRANT;
        timeout_o  = state_q == GRANT && wd_hit;
    end

    always_comb begin
        grant_d  = grant_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        weight_d = weight_q;
        credit_d = credit_q;
        if (state_q == IDLE) begin
            if (refill) credit_d = weight_q;
            if (found) begin
                grant_d = NUM_PORTS'(1) << win;
                gid_d   = win;
                beat_d  = BEAT_W'(1);
            end
        end else if (release_g) begin
            grant_d = '0;
            gid_d   = '0;
            beat_d  = '0;
            ptr_d   = gid_q == ID_W'(NUM_PORTS - 1) ? '0 : gid_q + ID_W'(1);
            if (credit_q[gid_q] != '0) credit_d[gid_q] = credit_q[gid_q] - WEIGHT_W'(1);
        end else if (beat && beat_q < BEAT_W'(MAX_BEATS)) begin
            beat_d = beat_q + BEAT_W'(1);
        end
        // New weights override both refill and end-of-packet credit updates.
        if (cfg_load_i) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                weight_d[i] = cfg_weight_i[i*WEIGHT_W +: WEIGHT_W];
                credit_d[i] = cfg_weight_i[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
                credit_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            grant_q  <= grant_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
            weight_q <= weight_d;
            credit_q <= credit_d;
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: scenario tasks with a queue of expected grant ids popped as grants appear.
module tb_wrr_burst_arbiter;
    import switch_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  req_i = '0, last_i = '0, grant_o;
    logic [15:0] cfg_weight_i = '0;
    logic        cfg_load_i = 1'b0;
    logic [1:0]  grant_id_o;
    logic        busy_o, timeout_o;
    int          n_cmp = 0, n_bad = 0;
    port_id_t    sb[$];

    wrr_burst_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4), .DEFAULT_WEIGHT(1), .MAX_BEATS(16), .BEAT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .last_i       (last_i),
        .cfg_weight_i (cfg_weight_i),
        .cfg_load_i   (cfg_load_i),
        .grant_o      (grant_o),
        .grant_id_o   (grant_id_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_i = '0; last_i = '0; cfg_load_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_ids(input int ids[$]);
        foreach (ids[i]) sb.push_back(port_id_t'(ids[i]));
    endtask

    // Serves plen-beat packets to whichever port the scoreboard expects, checking order and gaps.
    task automatic run_packets(input int n, input int plen);
        int done = 0, beats = 0, idle = 0, cyc = 0;
        logic in_pkt = 1'b0;
        port_id_t exp = '0;
        while (done < n && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (grant_o != '0) begin
                if (!in_pkt) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++; $display("FAIL sb_empty: unexpected grant %b", grant_o);
                    end else exp = sb.pop_front();
                    n_cmp++;
                    if (grant_o !== 4'(1 << exp) || grant_id_o !== exp || busy_o !== 1'b1) begin
                        n_bad++; $display("FAIL grant_order: got %b id %0d busy %b, expected id %0d", grant_o, grant_id_o, busy_o, exp);
                    end
                    n_cmp++;
                    if (done == 0 && cyc !== 1) begin
                        n_bad++; $display("FAIL grant_latency: got %0d cycles, expected 1", cyc);
                    end else if (done > 0 && idle !== 1) begin
                        n_bad++; $display("FAIL idle_gap: got %0d idle cycles, expected 1", idle);
                    end
                    in_pkt = 1'b1;
                    beats = 0;
                end else begin
                    n_cmp++;
                    if (grant_o !== 4'(1 << exp)) begin
                        n_bad++; $display("FAIL grant_hold: got %b, expected %b", grant_o, 4'(1 << exp));
                    end
                end
                beats++;
                last_i = '0;
                last_i[exp] = beats == plen;
            end else begin
                last_i = '0;
                n_cmp++;
                if (grant_id_o !== 2'd0 || busy_o !== 1'b0) begin
                    n_bad++; $display("FAIL idle_outputs: id %0d busy %b, expected 0 0", grant_id_o, busy_o);
                end
                if (in_pkt) begin
                    n_cmp++;
                    if (beats !== plen) begin
                        n_bad++; $display("FAIL packet_len: got %0d beats, expected %0d", beats, plen);
                    end
                    in_pkt = 1'b0;
                    done++;
                    idle = 0;
                end
                idle++;
            end
        end
        n_cmp++;
        if (done < n) begin
            n_bad++; $display("FAIL packets_done: got %0d packets, expected %0d", done, n);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL sb_leftover: %0d expected grants never seen", sb.size());
        end
        sb.delete();
        req_i = '0;
        last_i = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant_o, grant_id_o, busy_o, timeout_o} !== 8'h00) begin
            n_bad++; $display("FAIL reset_outputs: got %b %0d %b %b, expected all 0", grant_o, grant_id_o, busy_o, timeout_o);
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({grant_o, grant_id_o, busy_o, timeout_o} !== 8'h00) begin
            n_bad++; $display("FAIL post_reset_idle: got %b %0d %b %b, expected all 0", grant_o, grant_id_o, busy_o, timeout_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_i = 4'hF;
        push_ids('{0, 1, 2, 3, 0});
        run_packets(5, 2);
    endtask

    task automatic test_weights();
        do_reset();
        cfg_weight_i = {4'd1, 4'd1, 4'd1, 4'd3};
        cfg_load_i = 1'b1;
        @(negedge clk);
        cfg_load_i = 1'b0;
        req_i = 4'hF;
        push_ids('{0, 1, 2, 3, 0, 0, 1});
        run_packets(7, 1);
    endtask

    task automatic test_watchdog();
        int gcyc = 0, tcnt = 0, tat = 0, cyc = 0;
        port_id_t exp = '0;
        do_reset();
        req_i = 4'b0100;
        sb.push_back(port_id_t'(2));
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (timeout_o) begin
                tcnt++;
                tat = gcyc + 1;
            end
            if (grant_o != '0) begin
                if (gcyc == 0) exp = sb.pop_front();
                gcyc++;
                n_cmp++;
                if (grant_o !== 4'(1 << exp)) begin
                    n_bad++; $display("FAIL wd_grant: got %b, expected %b", grant_o, 4'(1 << exp));
                end
            end else if (gcyc > 0) break;
        end
        req_i = '0;
        n_cmp++;
        if (gcyc !== 16) begin
            n_bad++; $display("FAIL wd_grant_cycles: got %0d, expected 16", gcyc);
        end
        n_cmp++;
        if (tcnt !== 1 || tat !== 16) begin
            n_bad++; $display("FAIL wd_timeout_pulse: got %0d pulses at beat %0d, expected 1 at beat 16", tcnt, tat);
        end
        n_cmp++;
        if (cyc !== 17 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL wd_release: released at cycle %0d busy %b, expected 17 0", cyc, busy_o);
        end
    endtask

    task automatic test_zero_weight();
        do_reset();
        cfg_weight_i = {4'd1, 4'd1, 4'd0, 4'd1};
        cfg_load_i = 1'b1;
        @(negedge clk);
        cfg_load_i = 1'b0;
        req_i = 4'b0010;
        repeat (20) begin
            @(negedge clk);
            n_cmp++;
            if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
                n_bad++; $display("FAIL zero_weight: got grant %b busy %b, expected 0000 0", grant_o, busy_o);
            end
        end
        req_i = 4'b0011;
        push_ids('{0, 0});
        run_packets(2, 1);
    endtask

    task automatic test_abort();
        int cyc = 0, npk = 0, gcyc = 0, idle = 0;
        logic in_pkt = 1'b0;
        port_id_t exp = '0;
        do_reset();
        req_i = 4'b1000;
        push_ids('{3, 0});
        while (npk < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (timeout_o !== 1'b0) begin
                n_bad++; $display("FAIL abort_timeout: got %b, expected 0", timeout_o);
            end
            if (grant_o != '0) begin
                if (!in_pkt) begin
                    exp = sb.pop_front();
                    n_cmp++;
                    if (grant_o !== 4'(1 << exp) || grant_id_o !== exp) begin
                        n_bad++; $display("FAIL abort_order: got %b id %0d, expected id %0d", grant_o, grant_id_o, exp);
                    end
                    if (npk == 1) begin
                        n_cmp++;
                        if (idle !== 1) begin
                            n_bad++; $display("FAIL abort_gap: got %0d idle cycles, expected 1", idle);
                        end
                    end
                    in_pkt = 1'b1;
                    gcyc = 0;
                end
                gcyc++;
                if (exp == 2'd3 && gcyc == 2) req_i = 4'b1001;
                if (exp == 2'd3 && gcyc == 3) req_i = 4'b0001;
                if (exp == 2'd0) last_i = 4'b0001;
            end else begin
                if (in_pkt) begin
                    if (npk == 0) begin
                        n_cmp++;
                        if (gcyc !== 3) begin
                            n_bad++; $display("FAIL abort_len: got %0d grant cycles, expected 3", gcyc);
                        end
                    end
                    in_pkt = 1'b0;
                    npk++;
                    idle = 0;
                end
                idle++;
            end
        end
        req_i = '0;
        last_i = '0;
        n_cmp++;
        if (npk !== 2) begin
            n_bad++; $display("FAIL abort_done: got %0d packets, expected 2", npk);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req_i = 4'b0010;
        sb.push_back(port_id_t'(1));
        @(negedge clk);
        n_cmp++;
        if (grant_o !== 4'(1 << sb.pop_front()) || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL mid_grant_setup: got %b busy %b, expected 0010 1", grant_o, busy_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({grant_o, grant_id_o, busy_o, timeout_o} !== 8'h00) begin
            n_bad++; $display("FAIL async_reset: got %b %0d %b %b, expected all 0", grant_o, grant_id_o, busy_o, timeout_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_i = 4'hF;
        sb.push_back(port_id_t'(0));
        run_packets(1, 1);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_weights();
        test_watchdog();
        test_zero_weight();
        test_abort();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
